// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: result codes,
// controller state encoding and the chunk-count helper.
package cmp_pkg;

  localparam logic [1:0] CMP_LT = 2'b00;
  localparam logic [1:0] CMP_EQ = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_compare_cell.sv
// Combinational cascade cell: folds one MSB-first chunk of each operand into
// the running greater/equal code. A decided code passes through unchanged.
module chunk_compare_cell #(
  parameter int CHUNK = 1
) (
  input  logic [1:0]       cascade_in,
  input  logic [CHUNK-1:0] chunk_x,
  input  logic [CHUNK-1:0] chunk_y,
  output logic [1:0]       cascade_out
);

  logic g;
  logic e;

  assign g = cascade_in[1];
  assign e = cascade_in[0];

  assign cascade_out[1] = g | (e & (chunk_x > chunk_y));
  assign cascade_out[0] = e & (chunk_x == chunk_y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning CHUNK bits per cycle,
// MSB first, with early exit and a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one chunk compared per cycle, exits on first difference
// DONE  | done pulse; z valid; start accepted here without an idle gap
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [1:0]       z
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_magnitude_comparator: WIDTH must be at least 2");
  end
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_magnitude_comparator: WIDTH must be a multiple of CHUNK");
  end

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  xs;
  logic [WIDTH-1:0]  ys;
  logic [1:0]        c;
  logic [1:0]        c_nx;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              finish;

  chunk_compare_cell #(
    .CHUNK(CHUNK)
  ) u_cell (
    .cascade_in (c),
    .chunk_x    (xs[WIDTH-1 -: CHUNK]),
    .chunk_y    (ys[WIDTH-1 -: CHUNK]),
    .cascade_out(c_nx)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if ((c_nx != CMP_EQ) || (cnt == CW'(NCHUNK - 1))) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Flipping both MSBs turns a two's-complement compare into an unsigned one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs  <= '0;
      ys  <= '0;
      c   <= CMP_EQ;
      cnt <= '0;
      z   <= CMP_EQ;
    end else if (accept) begin
      xs  <= signed_mode ? (x ^ MSB_MASK) : x;
      ys  <= signed_mode ? (y ^ MSB_MASK) : y;
      c   <= CMP_EQ;
      cnt <= '0;
    end else if (state == RUN) begin
      c   <= c_nx;
      xs  <= xs << CHUNK;
      ys  <= ys << CHUNK;
      cnt <= cnt + CW'(1);
      if (finish) begin
        z <= c_nx;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: CHUNK=1 and CHUNK=4 instances checked
// every cycle against an arithmetic reference, plus literal directed cases.
module tb_serial_magnitude_comparator;

  localparam int W = 8;
  localparam logic [1:0] LT = 2'b00;
  localparam logic [1:0] EQ = 2'b01;
  localparam logic [1:0] GT = 2'b10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [W-1:0] x_v [2];
  logic [W-1:0] y_v [2];
  logic [1:0] sm_v = 2'b00;
  logic [1:0] busy_v;
  logic [1:0] done_v;
  logic [1:0] z_v [2];

  int n_checks = 0;
  int n_fail = 0;
  bit go = 1'b0;
  int chunk_of [2] = '{1, 4};

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(W), .CHUNK(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .x(x_v[0]), .y(y_v[0]),
    .signed_mode(sm_v[0]), .busy(busy_v[0]), .done(done_v[0]), .z(z_v[0])
  );

  serial_magnitude_comparator #(.WIDTH(W), .CHUNK(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .x(x_v[1]), .y(y_v[1]),
    .signed_mode(sm_v[1]), .busy(busy_v[1]), .done(done_v[1]), .z(z_v[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: arithmetic compare, latency from first differing chunk of x^y.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input int chunk,
                                 output logic [1:0] r, output int lat);
    int va, vb, diff, nch;
    va = sm ? int'($signed(a)) : int'(a);
    vb = sm ? int'($signed(b)) : int'(b);
    r = (va > vb) ? GT : ((va == vb) ? EQ : LT);
    diff = int'(a ^ b);
    nch = W / chunk;
    lat = nch;
    for (int i = 0; i < nch; i++) begin
      if (((diff >> (W - (i + 1) * chunk)) & ((1 << chunk) - 1)) != 0) begin
        lat = i + 1;
        break;
      end
    end
  endfunction

  bit         m_busy [2];
  bit         m_done [2];
  logic [1:0] m_z    [2];
  logic [1:0] m_pend [2];
  int         m_rem  [2];

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        m_z[d]    = EQ;
        m_rem[d]  = 0;
      end else if (m_busy[d]) begin
        m_rem[d] = m_rem[d] - 1;
        if (m_rem[d] == 0) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
          m_z[d]    = m_pend[d];
        end
      end else begin
        m_done[d] = 1'b0;
        if (start_v[d]) begin
          ref_op(x_v[d], y_v[d], sm_v[d], chunk_of[d], m_pend[d], m_rem[d]);
          m_busy[d] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cyc_busy%0d", d), 32'(busy_v[d]), 32'(m_busy[d]));
        chk($sformatf("cyc_done%0d", d), 32'(done_v[d]), 32'(m_done[d]));
        chk($sformatf("cyc_z%0d", d), 32'(z_v[d]), 32'(m_z[d]));
      end
    end
  end

  task automatic launch(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input bit now);
    if (!now) @(negedge clk);
    x_v[d] = a;
    y_v[d] = b;
    sm_v[d] = sm;
    start_v[d] = 1'b1;
    @(posedge clk);
  endtask

  // Returns at the negedge where done is seen; lat counts cycles accept->done.
  task automatic finish_op(input int d, input logic [1:0] ez, input int elat, input string nm);
    int n = 0;
    int nb = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start_v[d] = 1'b0;
        x_v[d] = W'($urandom);
        y_v[d] = W'($urandom);
      end
      if (busy_v[d]) nb++;
      if (done_v[d]) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(n - 1), 32'(elat));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(elat));
    chk({nm, "_z"}, 32'(z_v[d]), 32'(ez));
  endtask

  initial begin
    logic [1:0] r;
    int lat;
    logic [W-1:0] a, b;
    logic sm;
    int d;
    x_v[0] = '0; y_v[0] = '0; x_v[1] = '0; y_v[1] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy_v[k]), 32'd0);
      chk("rst_done", 32'(done_v[k]), 32'd0);
      chk("rst_z", 32'(z_v[k]), 32'(EQ));
    end
    reset = 1'b0;
    go = 1'b1;

    launch(0, 8'hA5, 8'hA5, 1'b0, 1'b0); finish_op(0, EQ, 8, "a5_eq");
    launch(0, 8'h80, 8'h7F, 1'b0, 1'b0); finish_op(0, GT, 1, "u80_7f");
    launch(0, 8'h80, 8'h7F, 1'b1, 1'b0); finish_op(0, LT, 1, "s80_7f");
    launch(0, 8'h00, 8'h00, 1'b0, 1'b0); finish_op(0, EQ, 8, "all_zero");
    launch(0, 8'hFF, 8'hFF, 1'b1, 1'b0); finish_op(0, EQ, 8, "all_one");
    launch(1, 8'h3C, 8'h3D, 1'b0, 1'b0); finish_op(1, LT, 2, "c4_3c_3d");
    launch(1, 8'h01, 8'h00, 1'b0, 1'b1); finish_op(1, GT, 2, "c4_b2b");
    launch(1, 8'h70, 8'h20, 1'b0, 1'b0); finish_op(1, GT, 1, "c4_early");

    // start pulsed mid-run must not disturb the 8'h12 vs 8'h12 compare
    launch(0, 8'h12, 8'h12, 1'b0, 1'b0);
    begin
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        start_v[0] = (n == 3);
        if (n == 3) begin
          x_v[0] = 8'h00;
          y_v[0] = 8'hFF;
        end
        if (done_v[0]) seen = 1'b1;
      end
      chk("busy_start_latency", 32'(n - 1), 32'd8);
      chk("busy_start_z", 32'(z_v[0]), 32'(EQ));
    end

    // reset in the third RUN cycle
    launch(0, 8'h80, 8'h00, 1'b0, 1'b0); finish_op(0, GT, 1, "pre_reset");
    launch(0, 8'h55, 8'h55, 1'b0, 1'b0);
    @(negedge clk) start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_z", 32'(z_v[0]), 32'(EQ));
    @(negedge clk) reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_v[0]), 32'd0);
    end
    launch(0, 8'hC3, 8'hC4, 1'b0, 1'b0); finish_op(0, LT, 6, "post_reset");

    repeat (160) begin
      d = int'($urandom_range(0, 1));
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      sm = 1'($urandom_range(0, 1));
      ref_op(a, b, sm, chunk_of[d], r, lat);
      launch(d, a, b, sm, bit'($urandom_range(0, 1)));
      finish_op(d, r, lat, "rnd");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
